// File: rtl/regfile_cmd_ctrl.sv
// Byte-command sequencer between the UART RX/TX paths and the config register file.
// Optional burst read (opcode CC) is built in when REGFILE_CMD_BURST_EN is defined.
module regfile_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int RF_DEPTH       = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter logic [DATA_WIDTH-1:0] ERR_BYTE = 8'hEE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VLD,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_Valid,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VLD,
  input  logic                  TX_BUSY,
  output logic                  CTRL_BUSY
);

  localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] DEPTH_D = DATA_WIDTH'(RF_DEPTH);
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_ADDR  = 4'd1;
  localparam logic [3:0] S_WR_DATA  = 4'd2;
  localparam logic [3:0] S_RD_ADDR  = 4'd3;
  localparam logic [3:0] S_RD_ISSUE = 4'd4;
  localparam logic [3:0] S_RD_WAIT  = 4'd5;
  localparam logic [3:0] S_TX_SEND  = 4'd6;
`ifdef REGFILE_CMD_BURST_EN
  localparam logic [3:0] S_BR_ADDR  = 4'd7;
  localparam logic [3:0] S_BR_CNT   = 4'd8;
  localparam logic [DATA_WIDTH-1:0] OP_BR = DATA_WIDTH'(8'hCC);
  localparam int CW = $clog2(RF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(RF_DEPTH - 1);
`endif

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  oor_q, oor_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  busy_q, busy_d;
  logic [15:0]           tmo_q, tmo_d;
  logic                  in_frame;
`ifdef REGFILE_CMD_BURST_EN
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] next_addr;
`endif

  always_comb begin
    in_frame = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA)
            || (state_q == S_RD_ADDR);
`ifdef REGFILE_CMD_BURST_EN
    in_frame = in_frame || (state_q == S_BR_ADDR) || (state_q == S_BR_CNT);
    // Out-of-range bursts never walk into the valid window.
    if (oor_q)
      next_addr = addr_q;
    else if (addr_q == LAST_A)
      next_addr = '0;
    else
      next_addr = addr_q + ADDR_WIDTH'(1);
`endif
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    oor_d     = oor_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    tmo_d     = '0;
`ifdef REGFILE_CMD_BURST_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (RX_VLD) begin
          unique case (1'b1)
            (RX_DATA == OP_WR): state_d = S_WR_ADDR;
            (RX_DATA == OP_RD): state_d = S_RD_ADDR;
`ifdef REGFILE_CMD_BURST_EN
            (RX_DATA == OP_BR): state_d = S_BR_ADDR;
`endif
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WR_ADDR: begin
        if (RX_VLD) begin
          addr_d  = RX_DATA[ADDR_WIDTH-1:0];
          oor_d   = (RX_DATA >= DEPTH_D);
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_VLD) begin
          if (!oor_q) begin
            wr_en_d   = 1'b1;
            rf_addr_d = addr_q;
            wr_data_d = RX_DATA;
          end
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_VLD) begin
          addr_d  = RX_DATA[ADDR_WIDTH-1:0];
          oor_d   = (RX_DATA >= DEPTH_D);
`ifdef REGFILE_CMD_BURST_EN
          cnt_d   = CW'(1);
`endif
          state_d = S_RD_ISSUE;
        end
      end
`ifdef REGFILE_CMD_BURST_EN
      S_BR_ADDR: begin
        if (RX_VLD) begin
          addr_d  = RX_DATA[ADDR_WIDTH-1:0];
          oor_d   = (RX_DATA >= DEPTH_D);
          state_d = S_BR_CNT;
        end
      end
      S_BR_CNT: begin
        if (RX_VLD) begin
          if (RX_DATA == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = (RX_DATA > DEPTH_D) ? DEPTH_C : RX_DATA[CW-1:0];
            state_d = S_RD_ISSUE;
          end
        end
      end
`endif
      S_RD_ISSUE: begin
        if (!oor_q) begin
          rd_en_d   = 1'b1;
          rf_addr_d = addr_q;
          state_d   = S_RD_WAIT;
        end else begin
          tx_data_d = ERR_BYTE;
          tx_vld_d  = 1'b1;
          state_d   = S_TX_SEND;
        end
      end
      S_RD_WAIT: begin
        if (RF_RdData_Valid) begin
          tx_data_d = RF_RdData;
          tx_vld_d  = 1'b1;
          state_d   = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        if (tx_vld_q && !TX_BUSY) begin
          tx_vld_d = 1'b0;
`ifdef REGFILE_CMD_BURST_EN
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q > CW'(1)) begin
            addr_d  = next_addr;
            state_d = S_RD_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d  = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Idle gap inside a frame; any accepted byte restarts the count.
    if (in_frame && !RX_VLD) begin
      tmo_d = tmo_q + 16'd1;
      if (tmo_d == TMO_LIM) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      oor_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rf_addr_q <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= '0;
`ifdef REGFILE_CMD_BURST_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      oor_q     <= oor_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      rf_addr_q <= rf_addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
`ifdef REGFILE_CMD_BURST_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_Address = rf_addr_q;
  assign RF_WrData  = wr_data_q;
  assign TX_DATA    = tx_data_q;
  assign TX_VLD     = tx_vld_q;
  assign CTRL_BUSY  = busy_q;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl: register-file model, TX monitor, directed plus random commands.
// Burst checks are compiled when REGFILE_CMD_BURST_EN is defined.
module tb_regfile_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VLD = 1'b0;
  logic       RF_WrEn, RF_RdEn;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData;
  logic [7:0] RF_RdData;
  logic       RF_RdData_Valid;
  logic [7:0] TX_DATA;
  logic       TX_VLD;
  logic       TX_BUSY = 1'b0;
  logic       CTRL_BUSY;

  regfile_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_BUSY(TX_BUSY),
    .CTRL_BUSY(CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  int ncmp = 0;
  int nfail = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int cyc = 0;
  logic rand_busy = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int acc_q[$];
  logic [7:0] mreg [8];
  logic [7:0] rf [8];

  // Register file the controller talks to.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      rf[2] <= 8'h81;
      rf[3] <= 8'h20;
      RF_RdData_Valid <= 1'b0;
      RF_RdData <= 8'h00;
    end else begin
      RF_RdData_Valid <= RF_RdEn;
      if (RF_RdEn) RF_RdData <= rf[RF_Address[2:0]];
      if (RF_WrEn) rf[RF_Address[2:0]] <= RF_WrData;
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST) begin
      if (TX_VLD && !TX_BUSY) begin
        got_q.push_back(TX_DATA);
        acc_q.push_back(cyc);
      end
      if (RF_WrEn) wr_cnt++;
      if (RF_RdEn) rd_cnt++;
      if (RF_WrEn || RF_RdEn) begin
        ncmp++;
        assert (!(RF_WrEn && RF_RdEn)) else begin
          nfail++;
          $error("FAIL strobe_excl: WrEn=%b RdEn=%b, required not both", RF_WrEn, RF_RdEn);
        end
      end
    end
  end

  always begin
    @(posedge CLK);
    #1;
    if (rand_busy) TX_BUSY = ($urandom_range(0, 2) == 0);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mreg[2] = 8'h81;
    mreg[3] = 8'h20;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a < 8) mreg[a[2:0]] = d;
  endtask

  task automatic model_read(input logic [7:0] a);
    exp_q.push_back((a < 8) ? mreg[a[2:0]] : 8'hEE);
  endtask

  task automatic model_burst(input logic [7:0] a, input logic [7:0] c);
    int n;
    n = (c > 8) ? 8 : int'(c);
    for (int i = 0; i < n; i++)
      exp_q.push_back((a < 8) ? mreg[(int'(a) + i) % 8] : 8'hEE);
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(posedge CLK);
    @(posedge CLK);
    #1;
    RX_DATA = b;
    RX_VLD = 1'b1;
    @(posedge CLK);
    #1;
    RX_VLD = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    model_write(a, d);
  endtask

  task automatic do_read(input logic [7:0] a);
    send_byte(8'hBB);
    send_byte(a);
    model_read(a);
  endtask

  task automatic do_burst(input logic [7:0] a, input logic [7:0] c);
    send_byte(8'hCC);
    send_byte(a);
    send_byte(c);
`ifdef REGFILE_CMD_BURST_EN
    model_burst(a, c);
`endif
  endtask

  task automatic wait_tx(output int k);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!TX_VLD && k < 20);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (CTRL_BUSY && n < 3000);
    if (n >= 3000) begin
      ncmp++;
      nfail++;
      $error("FAIL %s_idle: CTRL_BUSY still %b after %0d cycles, required 0", tag, CTRL_BUSY, n);
    end
  endtask

  task automatic check_q(input string tag);
    logic [7:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 8'hxx;
      if (got_q.size() > 0) g = got_q.pop_front();
      ncmp++;
      assert (g === e) else begin
        nfail++;
        $error("FAIL %s: tx byte observed %h expected %h", tag, g, e);
      end
    end
    ncmp++;
    assert (got_q.size() == 0) else begin
      nfail++;
      $error("FAIL %s_extra: observed %0d surplus tx bytes expected 0", tag, got_q.size());
    end
    got_q.delete();
  endtask

  initial begin
    int k, w0, r0;
    logic [7:0] a, d;
    int op;
    model_reset();

    // Reset held with traffic on RX: everything must stay at zero.
    RX_DATA = 8'hAA;
    RX_VLD = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_outs", 32'({RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
                           TX_DATA, TX_VLD, CTRL_BUSY}), 32'h0);
    RX_VLD = 1'b0;
    @(negedge CLK);
    RST = 1'b1;

    do_read(8'h02);
    wait_tx(k);
    chk("rd_latency", k, 4);
    wait_idle("rd2");
    do_read(8'h03);
    wait_idle("rd3");
    check_q("rd_reset_vals");

    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h5A);
    @(negedge CLK);
    chk("wr_pulse", 32'({RF_WrEn, RF_Address, RF_WrData}), 32'({1'b1, 4'h5, 8'h5A}));
    @(negedge CLK);
    chk("wr_pulse_end", 32'(RF_WrEn), 32'h0);
    model_write(8'h05, 8'h5A);
    do_read(8'h05);
    wait_idle("rd5");
    check_q("wr_then_rd");
    chk("wr_count", wr_cnt, w0 + 1);

    r0 = rd_cnt;
    do_read(8'h09);
    wait_tx(k);
    chk("oor_latency", k, 2);
    wait_idle("oor");
    chk("oor_no_rden", rd_cnt, r0);
    check_q("oor_err_byte");
    w0 = wr_cnt;
    do_write(8'h0C, 8'h11);
    wait_idle("oor_wr");
    chk("oor_no_wren", wr_cnt, w0);
    check_q("oor_wr_no_tx");

    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (1000) @(negedge CLK);
    chk("tmo_busy_999", 32'(CTRL_BUSY), 32'h1);
    @(negedge CLK);
    chk("tmo_busy_1000", 32'(CTRL_BUSY), 32'h0);
    do_read(8'h01);
    wait_idle("tmo_rd");
    check_q("tmo_rd1");
    chk("tmo_no_wren", wr_cnt, w0);

    TX_BUSY = 1'b1;
    do_read(8'h02);
    wait_tx(k);
    chk("busy_rd_latency", k, 4);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      RX_DATA = 8'hAA;
      RX_VLD = (i == 5);
      @(negedge CLK);
      chk("tx_hold", 32'({TX_VLD, TX_DATA}), 32'({1'b1, 8'h81}));
    end
    @(posedge CLK);
    #1;
    TX_BUSY = 1'b0;
    wait_idle("hold");
    chk("tx_vld_drop", 32'(TX_VLD), 32'h0);
    check_q("tx_hold_one");
    repeat (3) @(negedge CLK);
    chk("rx_dropped", 32'(CTRL_BUSY), 32'h0);

    send_byte(8'hAA);
    send_byte(8'h03);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_busy", 32'(CTRL_BUSY), 32'h0);
    RST = 1'b1;
    model_reset();
    w0 = wr_cnt;
    send_byte(8'h77);
    repeat (3) @(negedge CLK);
    chk("mid_rst_no_wr", wr_cnt, w0);
    chk("mid_rst_idle", 32'(CTRL_BUSY), 32'h0);
    do_read(8'h03);
    wait_idle("rst_rd");
    check_q("mid_rst_rd3");

`ifdef REGFILE_CMD_BURST_EN
    for (int i = 0; i < 8; i++) do_write(8'(i), 8'(8'h10 + i));
    wait_idle("fill");
    acc_q.delete();
    do_burst(8'h06, 8'h04);
    wait_idle("burst");
    chk("burst_acc_n", acc_q.size(), 4);
    if (acc_q.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("burst_spacing", acc_q[i] - acc_q[i-1], 4);
    check_q("burst_wrap");
    do_burst(8'h00, 8'h00);
    wait_idle("burst0");
    check_q("burst_cnt0");
    do_burst(8'h03, 8'h0A);
    wait_idle("burst_clamp");
    check_q("burst_clamp");
    r0 = rd_cnt;
    do_burst(8'h0F, 8'h03);
    wait_idle("burst_oor");
    chk("burst_oor_no_rden", rd_cnt, r0);
    check_q("burst_oor");
`else
    send_byte(8'hCC);
    send_byte(8'h06);
    send_byte(8'h04);
    repeat (3) @(negedge CLK);
    chk("cc_dropped", 32'(CTRL_BUSY), 32'h0);
    check_q("cc_no_tx");
`endif

    rand_busy = 1'b1;
    repeat (40) begin
      a = 8'($urandom_range(0, 11));
      d = 8'($urandom);
`ifdef REGFILE_CMD_BURST_EN
      op = $urandom_range(0, 2);
`else
      op = $urandom_range(0, 1);
`endif
      if (op == 0) do_write(a, d);
      else if (op == 1) do_read(a);
      else do_burst(a, 8'($urandom_range(0, 10)));
      wait_idle("rand");
      check_q("rand");
    end
    rand_busy = 1'b0;
    @(posedge CLK);
    #1;
    TX_BUSY = 1'b0;
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
